// File: rtl/mbist_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_ctrl
//   March C- BIST controller for a 2^ADDR x 1 RAM. Runs
//   {(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); (r0)} over every
//   cell. Each op takes one cycle. Read data is compared one edge after the
//   read is driven. The block reports pass/fail, the first failing
//   address/element and a saturating mismatch count.
//
//   Optional build macro: MBIST_STOP_ON_FAIL_EN
//     When defined, the test ends at the compare edge of the first mismatch.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   start      : begin test (honoured in IDLE or DONE)
//   cs/we/oe   : RAM chip select / write enable / read enable
//   addr       : RAM address
//   d_in       : RAM write data
//   d_out      : RAM read data (valid from the negedge of a read cycle)
//   busy       : test running
//   done       : test finished, held until restart or reset
//   fail       : sticky mismatch flag
//   fail_addr  : address of first mismatch
//   fail_elem  : March element (0-5) of first mismatch
//   err_cnt    : saturating mismatch count
// ---------------------------------------------------------------------------
module mbist_ctrl #(
   parameter int unsigned ADDR  = 6,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             cs,
   output logic             we,
   output logic             oe,
   output logic [ADDR-1:0]  addr,
   output logic             d_in,
   input  logic             d_out,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [ADDR-1:0]  fail_addr,
   output logic [2:0]       fail_elem,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [ADDR-1:0] A_LAST = '1;

   state_t     state;
   logic [2:0] elem;    // element of the op currently driven
   logic       ph;      // 0: first op of element, 1: second op
   logic       exp_r;   // expected read value of the op currently driven

   // Next-op computation from the op currently on the bus
   logic [2:0]      n_elem;
   logic            n_ph;
   logic [ADDR-1:0] n_addr;
   logic            n_we;
   logic            n_oe;
   logic            n_din;
   logic            n_exp;
   logic            last_op;
   logic            two_op;
   logic            down;
   logic            mismatch;
   logic            finish;

   always_comb begin
      n_elem  = elem;
      n_ph    = 1'b0;
      n_addr  = addr;
      last_op = 1'b0;
      two_op  = (elem >= 3'd1) && (elem <= 3'd4);
      down    = (elem == 3'd3) || (elem == 3'd4);

      if (two_op && !ph) begin
         n_ph = 1'b1;
      end else if (down ? (addr == '0) : (addr == A_LAST)) begin
         if (elem == 3'd5) begin
            last_op = 1'b1;
         end
         n_elem = elem + 3'd1;
         n_addr = ((n_elem == 3'd3) || (n_elem == 3'd4)) ? A_LAST : '0;
      end else begin
         n_addr = down ? (addr - 1'b1) : (addr + 1'b1);
      end

      // Element 0 is the only write-first element; every other element
      // starts with a read. r1 is expected in elements 2 and 4, w1 in 1 and 3.
      n_oe  = (n_elem != 3'd0) && !n_ph;
      n_we  = !n_oe;
      n_exp = (n_elem == 3'd2) || (n_elem == 3'd4);
      n_din = n_we && ((n_elem == 3'd1) || (n_elem == 3'd3));
   end

   // Case-inequality so an undriven or unknown read counts as a failure
   assign mismatch = oe && (d_out !== exp_r);

`ifdef MBIST_STOP_ON_FAIL_EN
   assign finish = last_op || mismatch;
`else
   assign finish = last_op;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         elem      <= '0;
         ph        <= 1'b0;
         exp_r     <= 1'b0;
         cs        <= 1'b0;
         we        <= 1'b0;
         oe        <= 1'b0;
         addr      <= '0;
         d_in      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         err_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_RUN;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  fail      <= 1'b0;
                  fail_addr <= '0;
                  fail_elem <= '0;
                  err_cnt   <= '0;
                  // op 0: element 0, w0 at address 0
                  elem      <= '0;
                  ph        <= 1'b0;
                  exp_r     <= 1'b0;
                  cs        <= 1'b1;
                  we        <= 1'b1;
                  oe        <= 1'b0;
                  addr      <= '0;
                  d_in      <= 1'b0;
               end
            end

            S_RUN: begin
               if (mismatch) begin
                  fail <= 1'b1;
                  if (err_cnt != '1) begin
                     err_cnt <= err_cnt + 1'b1;
                  end
                  if (!fail) begin
                     fail_addr <= addr;
                     fail_elem <= elem;
                  end
               end

               if (finish) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  elem  <= '0;
                  ph    <= 1'b0;
                  exp_r <= 1'b0;
                  cs    <= 1'b0;
                  we    <= 1'b0;
                  oe    <= 1'b0;
                  addr  <= '0;
                  d_in  <= 1'b0;
               end else begin
                  elem  <= n_elem;
                  ph    <= n_ph;
                  exp_r <= n_exp;
                  cs    <= 1'b1;
                  we    <= n_we;
                  oe    <= n_oe;
                  addr  <= n_addr;
                  d_in  <= n_din;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mbist_ctrl.sv
module tb_mbist_ctrl;

   localparam int unsigned ADDR  = 6;
   localparam int unsigned ERR_W = 8;
   localparam int unsigned NCELL = 1 << ADDR;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             cs, we, oe, d_in, busy, done, fail;
   logic             d_out;
   logic [ADDR-1:0]  addr, fail_addr;
   logic [2:0]       fail_elem;
   logic [ERR_W-1:0] err_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;

   mbist_ctrl #(.ADDR(ADDR), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cs(cs), .we(we), .oe(oe), .addr(addr), .d_in(d_in), .d_out(d_out),
      .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
      .fail_elem(fail_elem), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural 64x1 RAM with selectable fault:
   // 0 none, 1 stuck-at-0 at cell 4, 2 rising write to 17 forces 18 to 0
   int   fault = 0;
   logic mem [NCELL];

   initial d_out = 1'bz;

   always @(negedge clk) begin
      if (cs && we) begin
         if (fault == 2 && addr == 6'd17 && d_in && mem[17] !== 1'b1)
            mem[18] = 1'b0;
         mem[addr] = d_in;
      end
      if (fault == 1) mem[4] = 1'b0;
      d_out = (cs && oe) ? mem[addr] : 1'bz;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard
   typedef struct {
      int unsigned      len;
      logic             fl;
      logic [ADDR-1:0]  fa;
      logic [2:0]       fe;
      logic [ERR_W-1:0] ec;
   } exp_t;
   exp_t q[$];

   logic        busy_q = 1'b0;
   logic        done_q = 1'b0;
   int unsigned blen   = 0;

   always @(negedge clk) begin
      exp_t e;
      if (busy && !busy_q) blen = 1;
      else if (busy)       blen++;
      if (done && !done_q) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 expected no completion");
         end else begin
            e = q.pop_front();
            check("busy_len",  blen,      e.len);
            check("fail",      fail,      e.fl);
            check("fail_addr", fail_addr, e.fa);
            check("fail_elem", fail_elem, e.fe);
            check("err_cnt",   err_cnt,   e.ec);
            check("ram_ctrl_at_done", {cs, we, oe, d_in, addr}, 0);
         end
      end
      busy_q = busy;
      done_q = done;
   end

   task automatic push(input int unsigned len, input logic fl, input int unsigned fa,
                       input int unsigned fe, input int unsigned ec);
      exp_t e;
      e.len = len; e.fl = fl; e.fa = fa[ADDR-1:0]; e.fe = fe[2:0]; e.ec = ec[ERR_W-1:0];
      q.push_back(e);
   endtask

   task automatic start_pulse();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned limit);
      int unsigned n = 0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", limit);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctrl"},   {cs, we, oe, d_in}, 0);
      check({tag, "_addr"},   addr, 0);
      check({tag, "_status"}, {busy, done, fail}, 0);
      check({tag, "_diag"},   {fail_addr, fail_elem}, 0);
      check({tag, "_errcnt"}, err_cnt, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");

      // Fault-free run
      fault = 0;
      push(640, 1'b0, 0, 0, 0);
      start_pulse();
      wait_done(2000);
      repeat (5) begin
         @(negedge clk);
         check("no_access_after_done", {cs, we, oe, busy, done}, 5'b00001);
      end

      // Stuck-at-0 at cell 4
      fault = 1;
`ifdef MBIST_STOP_ON_FAIL_EN
      push(201, 1'b1, 4, 2, 1);
`else
      push(640, 1'b1, 4, 2, 2);
`endif
      start_pulse();
      wait_done(2000);

      // Coupling fault, started from DONE after a failing run
      fault = 2;
`ifdef MBIST_STOP_ON_FAIL_EN
      push(539, 1'b1, 18, 4, 1);
`else
      push(640, 1'b1, 18, 4, 1);
`endif
      start_pulse();
      check("restart_fail_clr",   fail,    0);
      check("restart_errcnt_clr", err_cnt, 0);
      check("restart_busy_done",  {busy, done}, 2'b10);
      // start pulses while running must be ignored
      repeat (50) @(negedge clk);
      start_pulse();
      repeat (250) @(negedge clk);
      start_pulse();
      wait_done(2000);

      // Reset mid-run at E100
      fault = 0;
      start_pulse();
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("midrun_rst");
      @(negedge clk);
      check("idle_after_rst", {busy, done, cs}, 0);
      push(640, 1'b0, 0, 0, 0);
      start_pulse();
      wait_done(2000);

      repeat (4) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
